// File: rtl/occ_pkg.sv
// Shared types and elaboration helpers for the multi-doorway occupancy tracker.
package occ_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        OUT_SEEN   = 2'd1,
        IN_SEEN    = 2'd2,
        WAIT_CLEAR = 2'd3
    } door_state_t;

    // Timer holds values 0..timeout-1, so it never needs more than clog2(timeout) bits.
    function automatic int timer_w(input int timeout);
        return (timeout <= 1) ? 1 : $clog2(timeout);
    endfunction

    function automatic bit params_legal(input int n_doors, input int cnt_w,
                                        input int max_occ, input int timeout);
        return (n_doors >= 1) && (timeout >= 1) && (cnt_w >= 1) && (cnt_w <= 30) &&
               (max_occ >= 0) && (max_occ < (1 << cnt_w));
    endfunction

endpackage

// File: rtl/occupancy_tracker_if.sv
// Sensor inputs and occupancy/event outputs of the occupancy tracker.
interface occupancy_tracker_if #(
    parameter int N_DOORS = 4,
    parameter int CNT_W   = 8
);
    logic [N_DOORS-1:0] sens_out;
    logic [N_DOORS-1:0] sens_in;
    logic               clear_err;
    logic [CNT_W-1:0]   occupancy;
    logic               occupied;
    logic               full;
    logic               ovf_err;
    logic               unf_err;
    logic [N_DOORS-1:0] entry_evt;
    logic [N_DOORS-1:0] exit_evt;
    logic [N_DOORS-1:0] abort_evt;

    modport master (
        output sens_out, sens_in, clear_err,
        input  occupancy, occupied, full, ovf_err, unf_err,
        input  entry_evt, exit_evt, abort_evt
    );

    modport slave (
        input  sens_out, sens_in, clear_err,
        output occupancy, occupied, full, ovf_err, unf_err,
        output entry_evt, exit_evt, abort_evt
    );
endinterface

// File: rtl/occ_door_fsm.sv
// One doorway: beam synchronisers, direction state machine, half-crossing timer
// and registered one-cycle entry/exit/abort pulses.
module occ_door_fsm
    import occ_pkg::*;
#(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic sens_out,
    input  logic sens_in,
    output logic entry_evt,
    output logic exit_evt,
    output logic abort_evt
);

    localparam int               TMR_W    = timer_w(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic              out_p0, out_p1, in_p0, in_p1;
    door_state_t       state, state_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt;
    logic              entry_nxt, exit_nxt, abort_nxt;

    // Stage p0/p1: two-flop synchronisers on the raw beam levels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_p0 <= 1'b0;
            out_p1 <= 1'b0;
            in_p0  <= 1'b0;
            in_p1  <= 1'b0;
        end else begin
            out_p0 <= sens_out;
            out_p1 <= out_p0;
            in_p0  <= sens_in;
            in_p1  <= in_p0;
        end
    end

    // Stage p2: state, timer and event pulses registered together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            entry_evt <= 1'b0;
            exit_evt  <= 1'b0;
            abort_evt <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            entry_evt <= entry_nxt;
            exit_evt  <= exit_nxt;
            abort_evt <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        entry_nxt = 1'b0;
        exit_nxt  = 1'b0;
        abort_nxt = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (out_p1 && !in_p1)      state_nxt = OUT_SEEN;
                else if (!out_p1 && in_p1) state_nxt = IN_SEEN;
                else if (out_p1 && in_p1)  state_nxt = WAIT_CLEAR;
            end
            // Completion is tested before the timer so it wins a same-cycle tie.
            OUT_SEEN: begin
                if (in_p1) begin
                    state_nxt = WAIT_CLEAR;
                    entry_nxt = 1'b1;
                end else if (!out_p1) begin
                    state_nxt = IDLE;
                end else if (timer == TMR_LAST) begin
                    state_nxt = WAIT_CLEAR;
                    abort_nxt = 1'b1;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            IN_SEEN: begin
                if (out_p1) begin
                    state_nxt = WAIT_CLEAR;
                    exit_nxt  = 1'b1;
                end else if (!in_p1) begin
                    state_nxt = IDLE;
                end else if (timer == TMR_LAST) begin
                    state_nxt = WAIT_CLEAR;
                    abort_nxt = 1'b1;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            WAIT_CLEAR: begin
                if (!out_p1 && !in_p1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/occupancy_tracker.sv
// Multi-doorway occupancy counter: per-door direction FSMs feeding a shared
// saturating head count with sticky overflow/underflow flags.
module occupancy_tracker
    import occ_pkg::*;
#(
    parameter int N_DOORS = 4,
    parameter int CNT_W   = 8,
    parameter int MAX_OCC = 200,
    parameter int TIMEOUT = 1000
) (
    input  logic                clk,
    input  logic                reset,
    occupancy_tracker_if.slave  bus
);

    localparam int                      SUM_W     = CNT_W + 2;
    localparam logic [CNT_W-1:0]        MAX_OCC_V = CNT_W'(MAX_OCC);
    localparam logic signed [SUM_W-1:0] MAX_SUM   = SUM_W'(MAX_OCC);

    if (!params_legal(N_DOORS, CNT_W, MAX_OCC, TIMEOUT)) begin : g_bad_params
        $error("occupancy_tracker: illegal N_DOORS/CNT_W/MAX_OCC/TIMEOUT combination");
    end

    typedef struct packed {
        logic [CNT_W-1:0] value;
        logic             ovf;
        logic             unf;
    } clip_t;

    function automatic logic signed [SUM_W-1:0] popcount(input logic [N_DOORS-1:0] v);
        logic signed [SUM_W-1:0] n;
        n = '0;
        for (int k = 0; k < N_DOORS; k++) n = n + $signed({{(SUM_W-1){1'b0}}, v[k]});
        return n;
    endfunction

    function automatic clip_t clip_occ(input logic signed [SUM_W-1:0] s);
        clip_t r;
        r.value = s[CNT_W-1:0];
        r.ovf   = 1'b0;
        r.unf   = 1'b0;
        if (s[SUM_W-1]) begin
            r.value = '0;
            r.unf   = 1'b1;
        end else if (s > MAX_SUM) begin
            r.value = MAX_OCC_V;
            r.ovf   = 1'b1;
        end
        return r;
    endfunction

    logic [N_DOORS-1:0]      entry_evt, exit_evt, abort_evt;
    logic signed [SUM_W-1:0] sum_p0;
    clip_t                   clip_p0;
    logic [CNT_W-1:0]        occ_p1;
    logic                    ovf_p1, unf_p1;

    for (genvar d = 0; d < N_DOORS; d++) begin : g_door
        occ_door_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
            .clk       (clk),
            .reset     (reset),
            .sens_out  (bus.sens_out[d]),
            .sens_in   (bus.sens_in[d]),
            .entry_evt (entry_evt[d]),
            .exit_evt  (exit_evt[d]),
            .abort_evt (abort_evt[d])
        );
    end

    // Stage p0: net all door events first, then clip once
    always_comb begin
        sum_p0  = $signed({2'b00, occ_p1}) + popcount(entry_evt) - popcount(exit_evt);
        clip_p0 = clip_occ(sum_p0);
    end

    // Stage p1: registered head count; a fresh error beats a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_p1 <= '0;
            ovf_p1 <= 1'b0;
            unf_p1 <= 1'b0;
        end else begin
            occ_p1 <= clip_p0.value;
            ovf_p1 <= clip_p0.ovf | (ovf_p1 & ~bus.clear_err);
            unf_p1 <= clip_p0.unf | (unf_p1 & ~bus.clear_err);
        end
    end

    assign bus.occupancy = occ_p1;
    assign bus.occupied  = (occ_p1 != '0);
    assign bus.full      = (occ_p1 == MAX_OCC_V);
    assign bus.ovf_err   = ovf_p1;
    assign bus.unf_err   = unf_p1;
    assign bus.entry_evt = entry_evt;
    assign bus.exit_evt  = exit_evt;
    assign bus.abort_evt = abort_evt;

endmodule

// File: tb/tb_occupancy_tracker.sv
// Scoreboard bench for occupancy_tracker: expected events and head-count states
// are queued as stimulus is driven and checked when the DUT should produce them.
module tb_occupancy_tracker;

    localparam int N_DOORS = 4;
    localparam int CNT_W   = 8;
    localparam int MAX_OCC = 200;
    localparam int TIMEOUT = 16;
    localparam int K_ENTRY = 0;
    localparam int K_EXIT  = 1;
    localparam int K_ABORT = 2;

    typedef struct { int at; int door; int kind; } ev_t;
    typedef struct { int at; int occ; bit ovf; bit unf; } occ_rec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_occ  = 0;
    bit   exp_ovf  = 1'b0;
    bit   exp_unf  = 1'b0;
    ev_t      evq[$];
    occ_rec_t occq[$];

    occupancy_tracker_if #(.N_DOORS(N_DOORS), .CNT_W(CNT_W)) bus ();

    occupancy_tracker #(
        .N_DOORS(N_DOORS), .CNT_W(CNT_W), .MAX_OCC(MAX_OCC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit evt_bit(input int d, input int k);
        case (k)
            K_ENTRY: return bus.entry_evt[d];
            K_EXIT:  return bus.exit_evt[d];
            default: return bus.abort_evt[d];
        endcase
    endfunction

    // Monitor: pop expectations as the DUT produces events / reaches scheduled cycles
    always @(negedge clk) begin
        for (int d = 0; d < N_DOORS; d++) begin
            for (int k = 0; k < 3; k++) begin
                if (evt_bit(d, k)) begin
                    if (evq.size() == 0) begin
                        check_eq($sformatf("unexpected_evt_door%0d_kind%0d", d, k), 1, 0);
                    end else begin
                        ev_t e;
                        e = evq.pop_front();
                        check_eq("evt_door", d, e.door);
                        check_eq("evt_kind", k, e.kind);
                        check_eq("evt_cycle", cyc, e.at);
                    end
                end
            end
        end
        while (evq.size() > 0 && evq[0].at < cyc) begin
            check_eq("missing_evt_at_cycle", -1, evq[0].at);
            void'(evq.pop_front());
        end
        while (occq.size() > 0 && occq[0].at <= cyc) begin
            occ_rec_t r;
            r = occq.pop_front();
            if (r.at != cyc) check_eq("occ_check_late", cyc, r.at);
            check_eq("occupancy", bus.occupancy, r.occ);
            check_eq("occupied", bus.occupied, r.occ != 0);
            check_eq("full", bus.full, r.occ == MAX_OCC);
            check_eq("ovf_err", bus.ovf_err, r.ovf);
            check_eq("unf_err", bus.unf_err, r.unf);
        end
    end

    task automatic drive(input logic [N_DOORS-1:0] o, input logic [N_DOORS-1:0] i,
                         input int hold);
        bus.sens_out = o;
        bus.sens_in  = i;
        repeat (hold) @(negedge clk);
    endtask

    task automatic expect_update(input int at, input int e, input int x);
        int s;
        s = exp_occ + e - x;
        if (s > MAX_OCC) begin
            exp_occ = MAX_OCC;
            exp_ovf = 1'b1;
        end else if (s < 0) begin
            exp_occ = 0;
            exp_unf = 1'b1;
        end else begin
            exp_occ = s;
        end
        occq.push_back('{at: at, occ: exp_occ, ovf: exp_ovf, unf: exp_unf});
    endtask

    task automatic push_now(input int at);
        occq.push_back('{at: at, occ: exp_occ, ovf: exp_ovf, unf: exp_unf});
    endtask

    // Full crossing on every door in m; clr pulses clear_err on the count-update edge.
    task automatic do_cross(input logic [N_DOORS-1:0] m, input bit is_exit, input bit clr);
        logic [N_DOORS-1:0] z;
        int c;
        int n;
        z = '0;
        n = $countones(m);
        if (is_exit) drive(z, m, 3);
        else         drive(m, z, 3);
        c = cyc;
        for (int d = 0; d < N_DOORS; d++)
            if (m[d]) evq.push_back('{at: c + 3, door: d, kind: is_exit ? K_EXIT : K_ENTRY});
        if (clr) begin
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end
        expect_update(c + 4, is_exit ? 0 : n, is_exit ? n : 0);
        drive(m, m, 1);
        if (is_exit) drive(m, z, 1);
        else         drive(z, m, 1);
        drive(z, z, 1);
        bus.clear_err = clr;
        drive(z, z, 1);
        bus.clear_err = 1'b0;
        drive(z, z, 2);
    endtask

    task automatic clear_flags();
        bus.clear_err = 1'b1;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        push_now(cyc + 1);
        drive('0, '0, 1);
        bus.clear_err = 1'b0;
        drive('0, '0, 2);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_occupancy"}, bus.occupancy, 0);
        check_eq({pfx, "_occupied"}, bus.occupied, 0);
        check_eq({pfx, "_full"}, bus.full, 0);
        check_eq({pfx, "_ovf_err"}, bus.ovf_err, 0);
        check_eq({pfx, "_unf_err"}, bus.unf_err, 0);
        check_eq({pfx, "_entry_evt"}, bus.entry_evt, 0);
        check_eq({pfx, "_exit_evt"}, bus.exit_evt, 0);
        check_eq({pfx, "_abort_evt"}, bus.abort_evt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bus.sens_out  = '0;
        bus.sens_in   = '0;
        bus.clear_err = 1'b0;
        #1 reset = 1'b1;
        #2 check_reset_outputs("por");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Entry on door 0, exit on door 0, then exit on door 2 underflows
        do_cross(4'b0001, 1'b0, 1'b0);
        do_cross(4'b0001, 1'b1, 1'b0);
        do_cross(4'b0100, 1'b1, 1'b0);
        clear_flags();

        // Back-outs produce nothing
        for (int r = 0; r < 5; r++) begin
            drive(4'b0010, '0, 2);
            drive('0, '0, 3);
        end
        push_now(cyc + 1);
        drive('0, '0, 2);

        // Half-crossing timeout on door 1, then normal entry resumes
        c = cyc;
        evq.push_back('{at: c + 3 + TIMEOUT, door: 1, kind: K_ABORT});
        push_now(c + 5 + TIMEOUT);
        drive(4'b0010, '0, TIMEOUT + 6);
        drive(4'b0010, 4'b0010, 3);
        drive('0, '0, 4);
        do_cross(4'b0010, 1'b0, 1'b0);

        // Fill to MAX_OCC-2, then four simultaneous entries clip at the ceiling
        for (int r = 0; r < 49; r++) do_cross(4'b1111, 1'b0, 1'b0);
        do_cross(4'b0001, 1'b0, 1'b0);
        do_cross(4'b1111, 1'b0, 1'b0);
        do_cross(4'b0001, 1'b0, 1'b1);
        clear_flags();

        // Drain down to 7
        for (int r = 0; r < 48; r++) do_cross(4'b1111, 1'b1, 1'b0);
        do_cross(4'b0001, 1'b1, 1'b0);

        // Reset mid-crossing on door 3; the stale crossing must not count
        drive(4'b1000, '0, 5);
        #2;
        reset = 1'b1;
        bus.sens_in = 4'b1000;
        #1 check_reset_outputs("async_rst");
        exp_occ = 0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(4'b1000, 4'b1000, 3);
        drive('0, 4'b1000, 2);
        drive('0, '0, 3);
        push_now(cyc + 1);
        drive('0, '0, 2);
        do_cross(4'b1000, 1'b0, 1'b0);

        drive('0, '0, 6);
        check_eq("evq_drained", evq.size(), 0);
        check_eq("occq_drained", occq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
